// File: rtl/debounce.sv
// rtl/debounce.sv - single-bit input debouncer; optional 2-flop input synchronizer under DEBOUNCE_SYNC_EN
// o_Data follows i_Data only after the change holds for DEBOUNCE_CYCLES consecutive edges.
module debounce #(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RST_VALUE       = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Data,
  output logic o_Data
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sample;
  logic [CNT_W-1:0] count_q, count_d;
  logic             data_q, data_d;

`ifdef DEBOUNCE_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = i_Data;
    sync2_d = sync1_q;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync1_q <= RST_VALUE;
      sync2_q <= RST_VALUE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sample = sync2_q;
`else
  assign sample = i_Data;
`endif

  // Counter only advances while the sample disagrees with the output, so it never exceeds CNT_LAST.
  always_comb begin
    count_d = '0;
    data_d  = data_q;
    if (sample != data_q) begin
      if (count_q == CNT_LAST) begin
        data_d = sample;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      count_q <= '0;
      data_q  <= RST_VALUE;
    end else begin
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  assign o_Data = data_q;

endmodule

// File: tb/tb_debounce.sv
// tb/tb_debounce.sv - self-checking bench for debounce (three parameterisations, sliding-window model)
// Build with DEBOUNCE_SYNC_EN defined to cover the synchronizer variant.
module tb_debounce;

`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic i_Clk = 1'b0;
  logic i_Rst = 1'b0;
  logic i_Data = 1'b0;
  logic o_dut [3];

  int checks = 0;
  int errors = 0;

  always #5 i_Clk = ~i_Clk;

  debounce #(.DEBOUNCE_CYCLES(4), .RST_VALUE(1'b0)) u_n4 (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Data(i_Data), .o_Data(o_dut[0]));
  debounce #(.DEBOUNCE_CYCLES(1), .RST_VALUE(1'b0)) u_n1 (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Data(i_Data), .o_Data(o_dut[1]));
  debounce #(.DEBOUNCE_CYCLES(3), .RST_VALUE(1'b1)) u_n3 (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Data(i_Data), .o_Data(o_dut[2]));

  function automatic int n_of(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic logic rv_of(input int i);
    return (i == 2) ? 1'b1 : 1'b0;
  endfunction

  // Model: output becomes v once the last N post-reset samples all equal v, otherwise holds.
  logic       exp_o [3];
  logic       p1 [3];
  logic       p2 [3];
  logic [7:0] win [3];
  int         seen [3];
  logic       smp;
  logic       same;
  bit         model_valid = 1'b0;

  always @(posedge i_Clk) begin
    for (int i = 0; i < 3; i++) begin
      if (i_Rst) begin
        exp_o[i] = rv_of(i);
        p1[i]    = rv_of(i);
        p2[i]    = rv_of(i);
        win[i]   = '0;
        seen[i]  = 0;
      end else if (model_valid) begin
`ifdef DEBOUNCE_SYNC_EN
        smp   = p2[i];
        p2[i] = p1[i];
        p1[i] = i_Data;
`else
        smp = i_Data;
`endif
        win[i] = {win[i][6:0], smp};
        if (seen[i] < 8) seen[i] = seen[i] + 1;
        if (seen[i] >= n_of(i)) begin
          same = 1'b1;
          for (int j = 0; j < n_of(i); j++)
            if (win[i][j] != smp) same = 1'b0;
          if (same) exp_o[i] = smp;
        end
      end
    end
    if (i_Rst) model_valid = 1'b1;
  end

  always @(negedge i_Clk) begin
    if (model_valid) begin
      for (int i = 0; i < 3; i++) begin
        checks = checks + 1;
        if (o_dut[i] !== exp_o[i]) begin
          errors = errors + 1;
          $display("FAIL model[%0d] t=%0t: o_Data=%b expected=%b", i, $time, o_dut[i], exp_o[i]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic got, input logic exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: o_Data=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic d);
    i_Rst  = r;
    i_Data = d;
    @(posedge i_Clk);
    #1;
  endtask

  int run_len;
  logic run_val;

  initial begin
    @(posedge i_Clk);
    #1;
    // Reset with i_Data high
    cyc(1'b1, 1'b1);
    chk("reset_n4", o_dut[0], 1'b0);
    chk("reset_n1", o_dut[1], 1'b0);
    chk("reset_n3_rstval", o_dut[2], 1'b1);

    // Glitch of 3 edges is filtered
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, 1'b1);
      chk("glitch_up_hold", o_dut[0], 1'b0);
      if (k == 1 + LAT) chk("n1_one_edge_delay", o_dut[1], 1'b1);
    end
    for (int k = 1; k <= 2 + LAT; k++) begin
      cyc(1'b0, 1'b0);
      chk("glitch_up_after", o_dut[0], 1'b0);
    end

    // Stable rise: changes after the (4+LAT)th edge
    for (int k = 1; k <= 4 + LAT; k++) begin
      cyc(1'b0, 1'b1);
      chk("rise_latency", o_dut[0], (k == 4 + LAT) ? 1'b1 : 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b1);
      chk("rise_stays", o_dut[0], 1'b1);
    end

    // Short drop of 2 edges is filtered
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b0);
      chk("glitch_down_hold", o_dut[0], 1'b1);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b1);
      chk("glitch_down_after", o_dut[0], 1'b1);
    end

    // Stable fall
    for (int k = 1; k <= 4 + LAT; k++) begin
      cyc(1'b0, 1'b0);
      chk("fall_latency", o_dut[0], (k == 4 + LAT) ? 1'b0 : 1'b1);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b0);
      chk("fall_stays", o_dut[0], 1'b0);
    end

    // Reset mid-count discards the partial count
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1);
      chk("pre_reset_count", o_dut[0], 1'b0);
    end
    cyc(1'b1, 1'b1);
    chk("mid_count_reset", o_dut[0], 1'b0);
    for (int k = 1; k <= 4 + LAT; k++) begin
      cyc(1'b0, 1'b1);
      chk("post_reset_latency", o_dut[0], (k == 4 + LAT) ? 1'b1 : 1'b0);
    end

    // Randomized runs with occasional resets
    for (int n = 0; n < 600; n++) begin
      run_len = $urandom_range(1, 7);
      run_val = 1'($urandom_range(0, 1));
      for (int k = 0; k < run_len; k++)
        cyc(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0, run_val);
    end

    @(posedge i_Clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce.md
DEBOUNCE -- requirements
Module: debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive clock cycles a changed input must hold before o_Data follows; legal range >= 1.
REQ-002 SHALL have parameter RST_VALUE, default 1'b0: value loaded into o_Data and all internal data flops on reset.
REQ-003 SHALL have port i_Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_Rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port i_Data, input, 1 bit: raw (bouncy) data input.
REQ-006 SHALL have port o_Data, output, 1 bit: debounced data, driven directly from a flop.

Function
REQ-007 SHALL hold an internal counter of width $clog2(DEBOUNCE_CYCLES+1) bits, with no wrap-around possible.
REQ-008 At each edge where the sampled input differs from o_Data and count+1 < DEBOUNCE_CYCLES, the counter SHALL increment and o_Data SHALL hold.
REQ-009 At the edge where the sampled input differs from o_Data and count+1 == DEBOUNCE_CYCLES, o_Data SHALL take the sampled input and the counter SHALL clear to 0.
REQ-010 At any edge where the sampled input equals o_Data, the counter SHALL clear to 0 and o_Data SHALL hold.
REQ-011 A change lasting fewer than DEBOUNCE_CYCLES consecutive edges SHALL never reach o_Data.
REQ-012 Latency: with the input stable from sampling edge k, o_Data SHALL change immediately after edge k+DEBOUNCE_CYCLES-1.
REQ-013 DEBOUNCE_CYCLES == 1: o_Data SHALL equal the sampled input delayed by one edge.
REQ-014 Rising and falling transitions SHALL be treated symmetrically.
REQ-015 The block SHALL be fully synchronous: no latches and no combinational path from i_Data to o_Data.

Reset
REQ-016 While i_Rst is high at a rising edge, o_Data SHALL become RST_VALUE, the counter SHALL become 0, and synchronizer flops (if present) SHALL become RST_VALUE.
REQ-017 Reset SHALL take priority over all counting; asserting it mid-count SHALL discard the partial count.
REQ-018 Counting SHALL restart from 0 at the first edge after reset deasserts.

Configuration
REQ-019 Macro DEBOUNCE_SYNC_EN defined: i_Data SHALL pass through a 2-flop synchronizer before sampling, adding exactly 2 cycles of latency.
REQ-020 Macro DEBOUNCE_SYNC_EN undefined: i_Data SHALL be sampled directly, with no extra latency; the function is otherwise identical.

Verification
REQ-021 Reset: hold i_Rst=1 for 1 edge with i_Data=1 -> o_Data=0, counter=0.
REQ-022 Glitch filter, DEBOUNCE_CYCLES=4: i_Data=1 for 3 edges then 0 -> o_Data stays 0 throughout.
REQ-023 Stable change: i_Data=1 held -> o_Data=1 after the 4th edge and stays 1; then i_Data=0 for 2 edges and back to 1 -> o_Data stays 1.
REQ-024 Falling edge: o_Data=1, i_Data=0 held -> o_Data=0 after the 4th edge.
REQ-025 Reset mid-count: i_Data=1 for 3 edges, i_Rst=1 on the 4th edge -> o_Data=0; after release, o_Data=1 only after 4 more edges.
REQ-026 With DEBOUNCE_SYNC_EN defined: stable i_Data step -> o_Data changes after the 6th edge.
